// File: rtl/ethernet_pkg.sv
// rtl/ethernet_pkg.sv - shared Ethernet stream widths and TX arbiter types
package ethernet_pkg;

    localparam int ETH_TDATA64    = 64;
    localparam int ETH_TKEEP64    = 8;
    localparam int ETH_TUSER64_TX = 1;

    localparam logic [ETH_TKEEP64-1:0] ARB_ABORT_KEEP        = 8'h01;
    localparam int                     ARB_STALL_MAX_DEFAULT = 1024;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2,
        ST_ABORT  = 2'd3
    } arb_state_e;

    // Returns 1 when port 1 should be granted; on contention the port not served last wins.
    function automatic logic rr_pick_port1(input logic v0, input logic v1, input logic last_served);
        if (v0 && v1) begin
            return ~last_served;
        end
        return v1 && !v0;
    endfunction

endpackage

// File: rtl/eth_tx_arb_if.sv
// rtl/eth_tx_arb_if.sv - 64-bit Ethernet stream bundle with source/sink views
interface eth_tx_arb_if;
    import ethernet_pkg::*;

    logic                      tvalid;
    logic                      tready;
    logic                      tlast;
    logic [ETH_TKEEP64-1:0]    tkeep;
    logic [ETH_TDATA64-1:0]    tdata;
    logic [ETH_TUSER64_TX-1:0] tuser;

    modport master (output tvalid, tlast, tkeep, tdata, tuser, input tready);
    modport slave  (input tvalid, tlast, tkeep, tdata, tuser, output tready);

endinterface

// File: rtl/eth_tx_arb.sv
// rtl/eth_tx_arb.sv - two-port packet-granular round-robin arbiter into the MAC TX stream
module eth_tx_arb
    import ethernet_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int STALL_MAX = ARB_STALL_MAX_DEFAULT
) (
    input  logic             eth_clk,
    input  logic             eth_rst_n,
    eth_tx_arb_if.slave      s0,
    eth_tx_arb_if.slave      s1,
    eth_tx_arb_if.master     m,
    output logic [CNT_W-1:0] pkt_cnt0,
    output logic [CNT_W-1:0] pkt_cnt1,
    output logic [15:0]      abort_cnt
);

    localparam int                 STALL_W   = (STALL_MAX > 0) ? $clog2(STALL_MAX + 1) : 1;
    localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(STALL_MAX);

    arb_state_e         state_q, state_d;
    logic               last_q, last_d;
    logic [STALL_W-1:0] stall_q, stall_d, stall_inc;
    logic [CNT_W-1:0]   cnt0_q, cnt0_d;
    logic [CNT_W-1:0]   cnt1_q, cnt1_d;
    logic [15:0]        abort_q, abort_d;

    logic                      g1;
    logic                      sel_valid;
    logic                      sel_last;
    logic [ETH_TKEEP64-1:0]    sel_keep;
    logic [ETH_TDATA64-1:0]    sel_data;
    logic [ETH_TUSER64_TX-1:0] sel_user;

    assign g1        = (state_q == ST_GRANT1);
    assign sel_valid = g1 ? s1.tvalid : s0.tvalid;
    assign sel_last  = g1 ? s1.tlast  : s0.tlast;
    assign sel_keep  = g1 ? s1.tkeep  : s0.tkeep;
    assign sel_data  = g1 ? s1.tdata  : s0.tdata;
    assign sel_user  = g1 ? s1.tuser  : s0.tuser;
    assign stall_inc = stall_q + STALL_W'(1);

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        stall_d   = stall_q;
        cnt0_d    = cnt0_q;
        cnt1_d    = cnt1_q;
        abort_d   = abort_q;
        m.tvalid  = 1'b0;
        m.tlast   = 1'b0;
        m.tkeep   = '0;
        m.tdata   = '0;
        m.tuser   = '0;
        s0.tready = 1'b0;
        s1.tready = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (s0.tvalid || s1.tvalid) begin
                    state_d = rr_pick_port1(s0.tvalid, s1.tvalid, last_q) ? ST_GRANT1 : ST_GRANT0;
                end
            end
            ST_GRANT0, ST_GRANT1: begin
                m.tvalid  = sel_valid;
                m.tlast   = sel_last;
                m.tkeep   = sel_keep;
                m.tdata   = sel_data;
                m.tuser   = sel_user;
                s0.tready = !g1 && m.tready;
                s1.tready = g1 && m.tready;
                if (sel_valid && m.tready) begin
                    stall_d = '0;
                    if (sel_last) begin
                        state_d = ST_IDLE;
                        last_d  = g1;
                        if (g1) begin
                            cnt1_d = cnt1_q + CNT_W'(1);
                        end else begin
                            cnt0_d = cnt0_q + CNT_W'(1);
                        end
                    end
                end else if (!sel_valid && (STALL_MAX != 0)) begin
                    // A source that went silent mid-packet would otherwise hold the MAC forever.
                    if (stall_inc == STALL_LIM) begin
                        state_d = ST_ABORT;
                        last_d  = g1;
                        stall_d = '0;
                    end else begin
                        stall_d = stall_inc;
                    end
                end
            end
            ST_ABORT: begin
                m.tvalid = 1'b1;
                m.tlast  = 1'b1;
                m.tkeep  = ARB_ABORT_KEEP;
                m.tuser  = '1;
                if (m.tready) begin
                    state_d = ST_IDLE;
                    abort_d = (abort_q == 16'hFFFF) ? abort_q : abort_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge eth_clk or negedge eth_rst_n) begin
        if (!eth_rst_n) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            stall_q <= '0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
            abort_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            stall_q <= stall_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
            abort_q <= abort_d;
        end
    end

    assign pkt_cnt0  = cnt0_q;
    assign pkt_cnt1  = cnt1_q;
    assign abort_cnt = abort_q;

endmodule

// File: doc/eth_tx_arb.md
ETH_TX_ARB -- requirements
Module: eth_tx_arb

Interface
REQ-001 Parameter CNT_W, default 32: width of the per-port packet counters.
REQ-002 Parameter STALL_MAX, default 1024: idle-cycle limit for a granted port before forced abort; 0 disables the limit.
REQ-003 eth_clk  in  1  sole clock; all logic on its rising edge.
REQ-004 eth_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 s0_tvalid / s0_tready / s0_tlast  in/out/in  1 each  port 0 (RX-snoop encap) AXI-Stream handshake.
REQ-006 s0_tkeep  in  8  port 0 byte enables (ETH_TKEEP64).
REQ-007 s0_tdata  in  64  port 0 data (ETH_TDATA64).
REQ-008 s0_tuser  in  1  port 0 error flag (ETH_TUSER64_TX).
REQ-009 s1_tvalid, s1_tready, s1_tlast, s1_tkeep, s1_tdata, s1_tuser: same widths as REQ-005..008 for port 1 (TX-snoop encap).
REQ-010 m_tvalid / m_tready / m_tlast  out/in/out  1 each  merged stream to the Ethernet MAC TX.
REQ-011 m_tkeep 8, m_tdata 64, m_tuser 1  out  merged stream payload.
REQ-012 pkt_cnt0, pkt_cnt1  out  CNT_W  packets forwarded per port.
REQ-013 abort_cnt  out  16  packets terminated by the stall watchdog.

Function
REQ-014 States: IDLE, GRANT0, GRANT1, ABORT; encoded in 2 bits.
REQ-015 IDLE: m_tvalid=0, s0_tready=s1_tready=0; no beat is accepted.
REQ-016 IDLE -> GRANTn on the cycle a port's tvalid=1; if both are valid, the port not served last wins (round-robin); after reset, port 0 wins.
REQ-017 Arbitration latency: first beat appears on m_* the cycle after the request is sampled in IDLE.
REQ-018 GRANTn: m_* = sn_* combinationally; sn_tready = m_tready; the other port's tready = 0.
REQ-019 A beat transfers when m_tvalid && m_tready.
REQ-020 Grant is held for the whole packet; it is never switched mid-packet.
REQ-021 GRANTn -> IDLE on the cycle a beat with tlast=1 transfers; last-served is set to n; pkt_cntn increments on that same cycle.
REQ-022 Back-to-back packets: one idle cycle (IDLE) separates consecutive packets; no zero-gap bursts.
REQ-023 Stall counter: cleared on each transferred beat; increments each GRANTn cycle with sn_tvalid=0.
REQ-024 When STALL_MAX != 0 and the stall count reaches STALL_MAX, GRANTn -> ABORT.
REQ-025 ABORT: drive one beat m_tvalid=1, m_tlast=1, m_tuser=1, m_tkeep=8'h01, m_tdata=0; sn_tready=0; on m_tready, go to IDLE, set last-served=n, increment abort_cnt.
REQ-026 After ABORT, remaining beats of the abandoned packet arriving on sn are arbitrated as a new packet; the MAC discards them via their own tuser/frame check, with no special handling in this block.
REQ-027 Counters wrap modulo 2^width silently; abort_cnt saturates at 16'hFFFF.
REQ-028 m_tready=0 holds all m_* outputs and the state stable; the stall counter does not increment while sn_tvalid=1.

Reset
REQ-029 eth_rst_n=0 asynchronously forces state=IDLE, last-served=1 (so port 0 wins first), stall counter=0, pkt_cnt0=pkt_cnt1=0, abort_cnt=0.
REQ-030 During reset and the first cycle after release: m_tvalid=0, m_tlast=0, m_tkeep=0, m_tdata=0, m_tuser=0, s0_tready=s1_tready=0.
REQ-031 Reset mid-packet truncates the packet on m_* without a tlast beat; the MAC recovers on its own.
REQ-032 Deassertion of reset is synchronized to eth_clk externally.

Structure
REQ-033 State enum, ARB_ABORT_KEEP (8'h01), and STALL_MAX default go in ethernet_pkg; stream widths reuse ETH_TDATA64/ETH_TKEEP64/ETH_TUSER64_TX.
REQ-034 Single module, no sub-modules; the counters and round-robin pointer are local registers.

Verification
REQ-035 Port 0 only, 8-beat packet, m_tready=1 -> 8 beats on m_*, tlast on beat 8, pkt_cnt0=1, s1_tready stays 0.
REQ-036 Both ports valid in the same cycle after reset -> port 0 packet first, then 1 IDLE cycle, then port 1; repeated contention alternates 0,1,0,1.
REQ-037 m_tready toggles 1010 during a port 1 packet -> no beat lost or duplicated; data matches the source byte-exactly.
REQ-038 Port 0 stalls after 3 beats with STALL_MAX=16 -> after 16 idle cycles one beat m_tlast=1, m_tuser=1, m_tkeep=8'h01; abort_cnt=1; grant returns to IDLE.
REQ-039 eth_rst_n pulsed low mid-packet -> all outputs 0 asynchronously, counters 0; the next request from port 0 wins.
REQ-040 2^CNT_W packets with CNT_W=4 -> pkt_cnt0 wraps 15->0; no side effects on the grant.
